// File: rtl/video_pkg.sv
// Shared types for the multi-mode video timing generator:
// mode descriptors, pixel word and a per-mode timing sanity check.
package video_pkg;

    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [23:0]        rgb_t;

    typedef struct packed {
        coord_t visible_w;
        coord_t visible_h;
        coord_t total_w;
        coord_t total_h;
        coord_t div;
    } mode_t;

    function automatic bit mode_ok(mode_t m, int x_pre, int y_pre, int hs_col);
        int vw, vh, tw, th;
        vw = int'(m.visible_w);
        vh = int'(m.visible_h);
        tw = int'(m.total_w);
        th = int'(m.total_h);
        return (tw >= vw + 2 + x_pre) && (th >= vh + 2 + y_pre) &&
               (tw - vw - x_pre > hs_col) && (m.div != '0) &&
               (vw > 0) && (vh > 0);
    endfunction

endpackage

// File: rtl/video_pixel_enable.sv
// Clock-per-pixel divider; the first clock after reset is a settle cycle
// so no sync pulse can appear while the design is still held in reset.
module video_pixel_enable #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         restart,
    input  logic [W-1:0] div,
    output logic         pix_en
);

    logic         run;
    logic [W-1:0] div_cnt;

    assign pix_en = run && (div_cnt == div - W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run     <= 1'b0;
            div_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (restart || pix_en)
                div_cnt <= '0;
            else if (run)
                div_cnt <= div_cnt + W'(1);
        end
    end

endmodule

// File: rtl/video_sync_modal.sv
// Multi-mode video timing generator; mode switches only take effect
// at the last pixel of a frame so downstream never sees a torn frame.
module video_sync_modal
    import video_pkg::*;
#(
    parameter int    NUM_MODES = 2,
    parameter mode_t MODES [NUM_MODES] = '{
        '{12'd4, 12'd3, 12'd10, 12'd6, 12'd1},
        '{12'd6, 12'd4, 12'd12, 12'd8, 12'd2}},
    parameter int    X_PRE   = 0,
    parameter int    Y_PRE   = 0,
    parameter int    HS_COL  = 4,
    parameter int    COORD_W = 12,
    // mode_sel is one bit wider than an index so out-of-range requests are expressible
    localparam int   SEL_W   = $clog2(NUM_MODES + 1),
    localparam int   AM_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode_req,
    input  logic [SEL_W-1:0]   mode_sel,
    output logic               mode_ack,
    output logic               mode_err,
    output logic [AM_W-1:0]    active_mode,
    output logic               vs,
    output logic               hs,
    output logic               de,
    output logic               skip,
    output logic [23:0]        rgb,
    output logic               line_start,
    output logic [COORD_W-1:0] x_index,
    output logic               x_index_valid,
    output logic [COORD_W-1:0] y_index,
    output logic               y_index_valid,
    input  logic [23:0]        rgb_in
);

    if (COORD_W != video_pkg::COORD_W) begin : g_bad_w
        $error("video_sync_modal: COORD_W must match video_pkg::COORD_W");
    end

    for (genvar i = 0; i < NUM_MODES; i++) begin : g_chk
        if (!mode_ok(MODES[i], X_PRE, Y_PRE, HS_COL)) begin : g_bad
            $error("video_sync_modal: mode %0d has invalid timing", i);
        end
    end

    mode_t             cur;
    coord_t            row, col;
    coord_t            de_col, de_row, x_lo, x_hi, y_lo, y_hi;
    logic              pix_en, bnd, apply, req_bad;
    logic              pend_v;
    logic [AM_W-1:0]   pend;

    assign cur = MODES[active_mode];

    video_pixel_enable #(.W(COORD_W)) u_pix_en (
        .clk     (clk),
        .reset   (reset),
        .restart (apply),
        .div     (cur.div),
        .pix_en  (pix_en)
    );

    assign bnd     = pix_en && (row == cur.total_h - 1'b1)
                            && (col == cur.total_w - 1'b1);
    assign apply   = bnd && pend_v;
    assign req_bad = mode_req && (mode_sel >= SEL_W'(NUM_MODES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row         <= '0;
            col         <= '0;
            active_mode <= '0;
            pend        <= '0;
            pend_v      <= 1'b0;
            mode_ack    <= 1'b0;
            mode_err    <= 1'b0;
        end else begin
            mode_ack <= apply;
            mode_err <= req_bad;
            if (pix_en) begin
                if (col == cur.total_w - 1'b1) begin
                    col <= '0;
                    row <= (row == cur.total_h - 1'b1) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (apply) begin
                active_mode <= pend;
                pend_v      <= 1'b0;
                row         <= '0;
                col         <= '0;
            end
            // a request on the boundary cycle lands here and waits a frame
            if (mode_req && !req_bad) begin
                pend   <= AM_W'(mode_sel);
                pend_v <= 1'b1;
            end
        end
    end

    assign de_col = cur.total_w - cur.visible_w;
    assign de_row = cur.total_h - cur.visible_h;
    assign x_lo   = de_col - coord_t'(X_PRE);
    assign x_hi   = cur.total_w - 1'b1 - coord_t'(X_PRE);
    assign y_lo   = de_row - coord_t'(Y_PRE);
    assign y_hi   = cur.total_h - 1'b1 - coord_t'(Y_PRE);

    assign de            = (row >= de_row) && (col >= de_col);
    assign skip          = de && !pix_en;
    assign rgb           = de ? rgb_in : '0;
    assign vs            = pix_en && (row == '0) && (col == '0);
    assign hs            = pix_en && (col == coord_t'(HS_COL));
    assign line_start    = pix_en && (col == '0);
    assign x_index_valid = (col >= x_lo) && (col <= x_hi);
    assign y_index_valid = (row >= y_lo) && (row <= y_hi);
    assign x_index       = x_index_valid ? col - x_lo : '0;
    assign y_index       = y_index_valid ? row - y_lo : '0;

endmodule

// File: tb/tb_video_sync_modal.sv
// Bench for video_sync_modal: directed mode scenarios plus random traffic,
// every output compared each clock against a frame-tick reference model.
module tb_video_sync_modal;
    import video_pkg::*;

    localparam int NM  = 2;
    localparam int XP  = 1;
    localparam int YP  = 1;
    localparam int HSC = 4;
    localparam mode_t TB_MODES [NM] = '{
        '{12'd4, 12'd3, 12'd10, 12'd6, 12'd1},
        '{12'd6, 12'd4, 12'd12, 12'd8, 12'd2}};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mode_req = 1'b0;
    logic [1:0]  mode_sel = '0;
    logic [23:0] rgb_in = '0;
    logic        mode_ack, mode_err, vs, hs, de, skip, line_start;
    logic        x_index_valid, y_index_valid;
    logic [0:0]  active_mode;
    logic [23:0] rgb;
    logic [11:0] x_index, y_index;

    video_sync_modal #(
        .NUM_MODES (NM),
        .MODES     (TB_MODES),
        .X_PRE     (XP),
        .Y_PRE     (YP),
        .HS_COL    (HSC),
        .COORD_W   (12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mode_req      (mode_req),
        .mode_sel      (mode_sel),
        .mode_ack      (mode_ack),
        .mode_err      (mode_err),
        .active_mode   (active_mode),
        .vs            (vs),
        .hs            (hs),
        .de            (de),
        .skip          (skip),
        .rgb           (rgb),
        .line_start    (line_start),
        .x_index       (x_index),
        .x_index_valid (x_index_valid),
        .y_index       (y_index),
        .y_index_valid (y_index_valid),
        .rgb_in        (rgb_in)
    );

    always #5 clk = ~clk;

    int n_vec, n_bad;
    int m_run, m_t, m_act, m_pv, m_pm, m_ack, m_err;
    bit o_vs, o_hs, o_de, o_ls, o_skip, o_ack, o_err;

    function automatic int vw(int a); return int'(TB_MODES[a].visible_w); endfunction
    function automatic int vh(int a); return int'(TB_MODES[a].visible_h); endfunction
    function automatic int tw(int a); return int'(TB_MODES[a].total_w);   endfunction
    function automatic int th(int a); return int'(TB_MODES[a].total_h);   endfunction
    function automatic int dv(int a); return int'(TB_MODES[a].div);       endfunction
    function automatic int flen(int a); return tw(a) * th(a) * dv(a);     endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0; m_act = 0; m_pv = 0; m_pm = 0; m_ack = 0; m_err = 0;
    endtask

    // Model position is a single clock tick count within the frame.
    task automatic compare_all();
        int d, p, col, row, xlo, ylo;
        bit pe, de_e, xv, yv;
        d    = dv(m_act);
        pe   = (m_run != 0) && (m_t % d == d - 1);
        p    = m_t / d;
        col  = p % tw(m_act);
        row  = p / tw(m_act);
        de_e = row >= th(m_act) - vh(m_act) && col >= tw(m_act) - vw(m_act);
        xlo  = tw(m_act) - vw(m_act) - XP;
        ylo  = th(m_act) - vh(m_act) - YP;
        xv   = col >= xlo && col < xlo + vw(m_act);
        yv   = row >= ylo && row < ylo + vh(m_act);
        check("vs", 32'(vs), 32'(pe && row == 0 && col == 0));
        check("hs", 32'(hs), 32'(pe && col == HSC));
        check("line_start", 32'(line_start), 32'(pe && col == 0));
        check("de", 32'(de), 32'(de_e));
        check("skip", 32'(skip), 32'(de_e && !pe));
        check("rgb", 32'(rgb), de_e ? 32'(rgb_in) : 32'd0);
        check("x_valid", 32'(x_index_valid), 32'(xv));
        check("x_index", 32'(x_index), xv ? 32'(col - xlo) : 32'd0);
        check("y_valid", 32'(y_index_valid), 32'(yv));
        check("y_index", 32'(y_index), yv ? 32'(row - ylo) : 32'd0);
        check("mode_ack", 32'(mode_ack), 32'(m_ack));
        check("mode_err", 32'(mode_err), 32'(m_err));
        check("active_mode", 32'(active_mode), 32'(m_act));
        o_vs = vs; o_hs = hs; o_de = de; o_ls = line_start;
        o_skip = skip; o_ack = mode_ack; o_err = mode_err;
    endtask

    task automatic model_step(bit req, int sel);
        bit bnd;
        bnd   = (m_run != 0) && (m_t == flen(m_act) - 1);
        m_ack = int'(bnd && m_pv != 0);
        m_err = int'(req && sel >= NM);
        if (m_run != 0) m_t = bnd ? 0 : m_t + 1;
        if (bnd && m_pv != 0) begin
            m_act = m_pm;
            m_pv  = 0;
        end
        if (req && sel < NM) begin
            m_pm = sel;
            m_pv = 1;
        end
        m_run = 1;
    endtask

    task automatic cycle(bit req, int sel, bit rst);
        @(negedge clk);
        reset    = rst;
        mode_req = rst ? 1'b0 : req;
        mode_sel = 2'(sel);
        rgb_in   = 24'($urandom);
        #1;
        compare_all();
        @(posedge clk);
        if (!rst) model_step(req, sel);
    endtask

    // Called right after a cycle, so reset rises mid-way through the high phase.
    task automatic do_reset(int n);
        #3;
        reset    = 1'b1;
        mode_req = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (n) cycle(0, 0, 1);
    endtask

    task automatic wait_vs();
        int n = 0;
        do begin
            cycle(0, 0, 0);
            n++;
        end while (!o_vs && n < 500);
        check("vs_seen", 32'(o_vs), 32'd1);
    endtask

    task automatic measure_frame(int a);
        int n = 0, de_n = 0, ls_n = 0, hs_n = 0, sk_n = 0;
        do begin
            cycle(0, 0, 0);
            n++;
            de_n += int'(o_de);
            ls_n += int'(o_ls);
            hs_n += int'(o_hs);
            sk_n += int'(o_skip);
        end while (!o_vs && n < 500);
        check("vs_period", 32'(n), 32'(flen(a)));
        check("de_per_frame", 32'(de_n), 32'(vw(a) * vh(a) * dv(a)));
        check("ls_per_frame", 32'(ls_n), 32'(th(a)));
        check("hs_per_frame", 32'(hs_n), 32'(th(a)));
        check("skip_per_frame", 32'(sk_n), 32'(vw(a) * vh(a) * (dv(a) - 1)));
    endtask

    task automatic run_count_acks(int n, output int acks);
        acks = 0;
        repeat (n) begin
            cycle(0, 0, 0);
            acks += int'(o_ack);
        end
    endtask

    initial begin
        int acks, n;
        n_vec = 0;
        n_bad = 0;
        model_reset();
        #1;
        reset = 1'b1;
        #1;
        compare_all();
        repeat (3) cycle(0, 0, 1);

        wait_vs();
        measure_frame(0);

        repeat (20) cycle(0, 0, 0);
        cycle(1, 1, 0);
        n = 0;
        do begin
            cycle(0, 0, 0);
            n++;
        end while (!o_ack && n < 200);
        check("switch_ack", 32'(o_ack), 32'd1);
        wait_vs();
        measure_frame(1);

        cycle(1, 1, 0);
        repeat (10) cycle(0, 0, 0);
        cycle(1, 0, 0);
        run_count_acks(2 * flen(1) + 10, acks);
        check("two_req_acks", 32'(acks), 32'd1);
        check("two_req_mode", 32'(active_mode), 32'd0);

        cycle(1, 2, 0);
        cycle(0, 0, 0);
        check("sel2_err", 32'(o_err), 32'd1);
        run_count_acks(flen(0) + 5, acks);
        check("sel2_no_ack", 32'(acks), 32'd0);

        n = 0;
        while (!(m_run != 0 && m_t == flen(m_act) - 1) && n < 500) begin
            cycle(0, 0, 0);
            n++;
        end
        cycle(1, 1, 0);
        cycle(0, 0, 0);
        check("bnd_req_deferred", 32'(o_ack), 32'd0);
        run_count_acks(flen(0) + 5, acks);
        check("bnd_req_acks", 32'(acks), 32'd1);

        cycle(1, 0, 0);
        repeat (30) cycle(0, 0, 0);
        do_reset(3);
        run_count_acks(400, acks);
        check("reset_no_ack", 32'(acks), 32'd0);
        check("reset_mode", 32'(active_mode), 32'd0);

        repeat (3000) begin
            if ($urandom_range(0, 999) == 0)
                do_reset(2);
            else
                cycle($urandom_range(0, 39) == 0, int'($urandom_range(0, 3)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
